sprite_fb_writer: RTL and testbench
===================================

Name: sprite_fb_writer

Overview:
- Copies a rectangular sprite from a sprite ROM into the 420x260, 8-bit-per-pixel frame buffer RAM.
- The display path reads that RAM with 3x scaling, so this block is the write end of the same buffer.
- Takes one blit command at a time over a valid/ready handshake.
- Clips against frame-buffer bounds, optionally skips a transparent key colour, and writes only while the timing side grants access (wr_allow).

Parameters:
- FB_W, 420: frame-buffer width in pixels.
- FB_H, 260: frame-buffer height in pixels.
- FB_AW, 17: frame-buffer address width.
- DW, 8: pixel width.
- SPR_AW, 12: sprite ROM address width.
- KEY, 8'h00: transparent colour value.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- cmd_valid  in  1  blit command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  10  signed destination x of the sprite's top-left pixel.
- cmd_y  in  10  signed destination y of the sprite's top-left pixel.
- cmd_w  in  7  sprite width in pixels; 0 is legal.
- cmd_h  in  7  sprite height in pixels; 0 is legal.
- cmd_base  in  SPR_AW  ROM address of sprite pixel (0,0).
- cmd_key_en  in  1  enable transparency.
- wr_allow  in  1  frame-buffer write window, from the timing side.
- spr_addr  out  SPR_AW  sprite ROM address. ROM returns data 1 cycle later.
- spr_data  in  DW  sprite ROM data.
- fb_we  out  1  frame-buffer write strobe.
- fb_addr  out  FB_AW  frame-buffer write address.
- fb_wdata  out  DW  frame-buffer write data.
- busy  out  1  high from command accept until the cycle before done.
- done  out  1  single-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 immediately: cmd_ready, spr_addr, fb_we, fb_addr, fb_wdata, busy, done.
  - FSM goes to IDLE; counters clear.
  - Reset during a blit abandons it; no done pulse is produced.
- Command accept:
  - Accept when cmd_valid && cmd_ready. cmd_ready=1 only in IDLE.
  - On accept, latch all cmd_* fields; clear row and col to 0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on accept, if w!=0 and h!=0.
  - IDLE -> DONE on accept, if w==0 or h==0. No reads and no writes occur.
  - RUN: in any cycle with wr_allow=1, issue one pixel:
    - spr_addr = cmd_base + row*cmd_w + col, modulo 2^SPR_AW.
    - Advance col; at col==w-1, wrap col to 0 and increment row.
  - RUN with wr_allow=0: nothing is issued and the counters hold.
  - RUN -> DRAIN in the cycle the last pixel (row=h-1, col=w-1) is issued.
  - DRAIN -> DONE after 1 cycle.
  - DONE -> IDLE after 1 cycle. done=1 in DONE only.
  - busy=1 in RUN and DRAIN.
- Write stage (one cycle after issue):
  - px = cmd_x + col, py = cmd_y + row, both sign-extended to 11 bits.
  - fb_we=1 iff 0<=px<FB_W, 0<=py<FB_H, and not (cmd_key_en && spr_data==KEY).
  - fb_addr = py*FB_W + px; fb_wdata = spr_data.
  - When fb_we=0, fb_addr and fb_wdata hold their previous values.
  - A pixel already issued is written in the next cycle even if wr_allow has dropped. The timing side guarantees wr_allow falls at least 1 cycle before the display read region.
- Timing:
  - Accept at cycle 0; first issue no earlier than cycle 1.
  - With wr_allow held at 1: last write at cycle w*h+1, done at cycle w*h+2, cmd_ready back at w*h+3.
  - Each cycle of wr_allow=0 during RUN delays done by 1 cycle.
  - Clipped and keyed pixels still consume their issue cycle; the latency formula is unchanged.
- Arithmetic: the row*cmd_w and py*FB_W products are computed at full width, then truncated to the address width.
- Simultaneous events: cmd_valid asserted in DONE is not accepted until IDLE.

Test Plan:
- 4x2 sprite at (0,0), base 0, key off, wr_allow=1 -> exactly 8 writes, fb_addr 0,1,2,3,420,421,422,423, data equal to ROM[0..7]; done at cycle 10; cmd_ready at cycle 11.
- Same blit, key on, ROM[1]=8'h00 -> write to address 1 suppressed; the other 7 writes occur; done still at cycle 10.
- Clipping: x=-2 (10'h3FE), y=258, 4x4 sprite -> only 4 writes, at 108360, 108361, 108780, 108781; done at cycle 18.
- wr_allow low for 5 cycles after the 3rd issue -> spr_addr frozen; only the 3rd pixel's write occurs during the gap; done at cycle 15 for a 4x2 sprite.
- cmd_w=0 -> no spr_addr change and no fb_we; done at cycle 1; cmd_ready at cycle 2.
- rst pulsed low mid-RUN -> fb_we, busy and done drop to 0 in the same cycle with no clock edge; after release, cmd_ready=1 and the next command runs correctly.

Source files
------------

// File: rtl/sprite_fb_writer_if.sv
// Blit command channel into sprite_fb_writer.
// A command transfers on a rising clock edge where cmd_valid && cmd_ready. The master
// holds every cmd_* field stable while cmd_valid is high. It may not withdraw cmd_valid
// before the transfer. The slave may raise or drop cmd_ready without regard to cmd_valid.
interface sprite_fb_writer_if #(
    parameter int SPR_AW = 12
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [6:0]        cmd_w;
    logic [6:0]        cmd_h;
    logic [SPR_AW-1:0] cmd_base;
    logic              cmd_key_en;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, cmd_key_en,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_base, cmd_key_en,
        output cmd_ready
    );
endinterface

// File: rtl/sprite_fb_writer.sv
// Copies a clipped, optionally colour-keyed sprite from ROM into the frame buffer.
// The block issues one ROM read per granted cycle and performs the matching write one cycle later.
module sprite_fb_writer #(
    parameter int             FB_W   = 420,
    parameter int             FB_H   = 260,
    parameter int             FB_AW  = 17,
    parameter int             DW     = 8,
    parameter int             SPR_AW = 12,
    parameter logic [DW-1:0]  KEY    = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    sprite_fb_writer_if.slave cmd,
    input  logic              wr_allow,
    output logic [SPR_AW-1:0] spr_addr,
    input  logic [DW-1:0]     spr_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [DW-1:0]     fb_wdata,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int          PW     = 11;
    localparam logic [PW-1:0] FB_W_L = PW'(FB_W);
    localparam logic [PW-1:0] FB_H_L = PW'(FB_H);

    logic [1:0]        state, state_n;
    logic              ready_q;
    logic [9:0]        x_q, y_q;
    logic [6:0]        w_q, h_q, row, col;
    logic [SPR_AW-1:0] base_q, spr_addr_q, spr_addr_n;
    logic              key_q;
    logic              iss_q;
    logic [PW-1:0]     px_q, py_q, px_n, py_n;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_n;
    logic [DW-1:0]     fb_wdata_q;
    logic              accept, zero_sz, issue, last_px, col_wrap, in_bounds, keyed;

    assign accept   = cmd.cmd_valid && ready_q;
    assign zero_sz  = (cmd.cmd_w == 7'd0) || (cmd.cmd_h == 7'd0);
    assign issue    = (state == RUN) && wr_allow;
    assign col_wrap = (col == w_q - 7'd1);
    assign last_px  = col_wrap && (row == h_q - 7'd1);

    // Both products are formed directly at address width, which is the full-width result modulo 2^width.
    assign spr_addr_n = base_q + SPR_AW'(row) * SPR_AW'(w_q) + SPR_AW'(col);
    assign px_n       = {x_q[9], x_q} + {4'b0000, col};
    assign py_n       = {y_q[9], y_q} + {4'b0000, row};

    assign in_bounds = !px_q[PW-1] && (px_q < FB_W_L) && !py_q[PW-1] && (py_q < FB_H_L);
    assign keyed     = key_q && (spr_data == KEY);
    assign fb_addr_n = FB_AW'(py_q) * FB_AW'(FB_W) + FB_AW'(px_q);

    // Addresses and data stay at their last used values between strobes.
    assign spr_addr  = issue ? spr_addr_n : spr_addr_q;
    assign fb_we     = iss_q && in_bounds && !keyed;
    assign fb_addr   = fb_we ? fb_addr_n : fb_addr_q;
    assign fb_wdata  = fb_we ? spr_data : fb_wdata_q;

    assign cmd.cmd_ready = ready_q;
    assign busy          = (state == RUN) || (state == DRAIN);
    assign done          = (state == DONE);
    assign dbg_state     = state;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = zero_sz ? DONE : RUN;
            RUN:     if (issue && last_px) state_n = DRAIN;
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            base_q     <= '0;
            key_q      <= 1'b0;
            row        <= '0;
            col        <= '0;
            iss_q      <= 1'b0;
            px_q       <= '0;
            py_q       <= '0;
            spr_addr_q <= '0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            state   <= state_n;
            ready_q <= (state_n == IDLE);
            iss_q   <= issue;
            if (accept) begin
                x_q    <= cmd.cmd_x;
                y_q    <= cmd.cmd_y;
                w_q    <= cmd.cmd_w;
                h_q    <= cmd.cmd_h;
                base_q <= cmd.cmd_base;
                key_q  <= cmd.cmd_key_en;
                row    <= '0;
                col    <= '0;
            end else if (issue) begin
                spr_addr_q <= spr_addr_n;
                px_q       <= px_n;
                py_q       <= py_n;
                if (col_wrap) begin
                    col <= '0;
                    row <= row + 7'd1;
                end else begin
                    col <= col + 7'd1;
                end
            end
            if (fb_we) begin
                fb_addr_q  <= fb_addr_n;
                fb_wdata_q <= spr_data;
            end
        end
    end
endmodule

// File: tb/tb_sprite_fb_writer.sv
// Randomized scoreboard bench for sprite_fb_writer: the driver pushes model writes, and the monitor pops them on fb_we.
module tb_sprite_fb_writer;
  localparam int FB_W   = 420;
  localparam int FB_H   = 260;
  localparam int FB_AW  = 17;
  localparam int DW     = 8;
  localparam int SPR_AW = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              wr_allow = 1'b0;
  logic [SPR_AW-1:0] spr_addr;
  logic [DW-1:0]     spr_data;
  logic              fb_we;
  logic [FB_AW-1:0]  fb_addr;
  logic [DW-1:0]     fb_wdata;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  sprite_fb_writer_if #(.SPR_AW(SPR_AW)) cmd_if ();

  sprite_fb_writer #(
    .FB_W(FB_W), .FB_H(FB_H), .FB_AW(FB_AW), .DW(DW), .SPR_AW(SPR_AW), .KEY(8'h00)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if), .wr_allow(wr_allow),
    .spr_addr(spr_addr), .spr_data(spr_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // sprite ROM with one cycle of read latency
  logic [DW-1:0] rom [0:4095];
  always @(posedge clk) spr_data <= rom[spr_addr];

  // scoreboard
  logic [FB_AW+DW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b1;
  logic [SPR_AW-1:0] last_spr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [FB_AW+DW-1:0] e;
    if (rst && mon_en && fb_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL fb_write_unexpected: got addr=%0d data=%0h, expected no write", fb_addr, fb_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({fb_addr, fb_wdata} !== e) begin
          n_err++;
          $display("FAIL fb_write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   fb_addr, fb_wdata, e[FB_AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver: one blit. rnd selects random wr_allow; otherwise a single gap of gap_len after gap_after issues
  task automatic run_cmd(input int x, input int y, input int w, input int h, input int base,
                         input bit key, input bit rnd, input int gap_after, input int gap_len);
    int n, cnt, exp_done, cyc, gap_left, px, py, sa;
    bit a, iss;
    logic [SPR_AW-1:0] exp_sa;
    n = w * h;
    cnt = 0;
    gap_left = gap_len;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        px = x + c;
        py = y + r;
        sa = (base + r * w + c) % 4096;
        if (px >= 0 && px < FB_W && py >= 0 && py < FB_H && !(key && rom[sa] == 8'h00))
          exp_q.push_back({FB_AW'(py * FB_W + px), rom[sa]});
      end
    end
    exp_done = (n == 0) ? 1 : (1 << 30);

    @(posedge clk); #1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_x      = 10'(x);
    cmd_if.cmd_y      = 10'(y);
    cmd_if.cmd_w      = 7'(w);
    cmd_if.cmd_h      = 7'(h);
    cmd_if.cmd_base   = SPR_AW'(base);
    cmd_if.cmd_key_en = key;
    wr_allow          = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_if.cmd_ready), 1);
    check("spr_addr_idle", 32'(spr_addr), 32'(last_spr));
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    cyc = 1;
    while (cyc <= exp_done + 1) begin
      if (rnd) a = (cyc > 3000) || ($urandom_range(0, 3) != 0);
      else if (gap_after >= 0 && cnt == gap_after && gap_left > 0) begin
        a = 1'b0;
        gap_left--;
      end else a = 1'b1;
      wr_allow = a;
      iss = a && (cnt < n);
      if (iss) begin
        exp_sa = SPR_AW'((base + cnt) % 4096);
        cnt++;
        if (cnt == n) exp_done = cyc + 2;
      end else exp_sa = last_spr;
      @(negedge clk);
      check("spr_addr", 32'(spr_addr), 32'(exp_sa));
      check("busy", 32'(busy), 32'(n > 0 && cyc < exp_done));
      check("done", 32'(done), 32'(cyc == exp_done));
      check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(cyc == exp_done + 1));
      last_spr = exp_sa;
      @(posedge clk); #1;
      cyc++;
    end
    check("writes_left", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_run();
    mon_en = 1'b0;
    @(posedge clk); #1;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_x      = 10'd0;
    cmd_if.cmd_y      = 10'd0;
    cmd_if.cmd_w      = 7'd8;
    cmd_if.cmd_h      = 7'd8;
    cmd_if.cmd_base   = '0;
    cmd_if.cmd_key_en = 1'b0;
    wr_allow          = 1'b1;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_fb_we", 32'(fb_we), 1);
    check("pre_rst_busy", 32'(busy), 1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd_ready", 32'(cmd_if.cmd_ready), 0);
    check("rst_spr_addr", 32'(spr_addr), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    #4;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_if.cmd_ready), 1);
    check("post_rst_done", 32'(done), 0);
    exp_q.delete();
    last_spr = '0;
    mon_en = 1'b1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++)
      rom[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    for (int i = 0; i < 16; i++) rom[i] = 8'(i + 8'h20);
    rom[1] = 8'h00;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_x      = '0;
    cmd_if.cmd_y      = '0;
    cmd_if.cmd_w      = '0;
    cmd_if.cmd_h      = '0;
    cmd_if.cmd_base   = '0;
    cmd_if.cmd_key_en = 1'b0;

    #1 rst = 1'b0;
    #1;
    check("reset_cmd_ready", 32'(cmd_if.cmd_ready), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_fb_we", 32'(fb_we), 0);
    check("reset_spr_addr", 32'(spr_addr), 0);
    check("reset_fb_wdata", 32'(fb_wdata), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // directed cases
    run_cmd(0, 0, 4, 2, 0, 1'b0, 1'b0, -1, 0);
    run_cmd(0, 0, 4, 2, 0, 1'b1, 1'b0, -1, 0);
    run_cmd(-2, 258, 4, 4, 40, 1'b0, 1'b0, -1, 0);
    run_cmd(0, 0, 4, 2, 0, 1'b0, 1'b0, 3, 5);
    run_cmd(10, 10, 0, 5, 100, 1'b0, 1'b0, -1, 0);
    run_cmd(10, 10, 5, 0, 200, 1'b0, 1'b0, -1, 0);
    run_cmd(418, 257, 4, 4, 4090, 1'b1, 1'b0, -1, 0);
    reset_mid_run();
    run_cmd(3, 5, 4, 3, 8, 1'b0, 1'b0, -1, 0);

    // randomized blits
    for (int k = 0; k < 40; k++) begin
      int x, y, w, h, b;
      x = int'($urandom_range(0, 600)) - 140;
      y = int'($urandom_range(0, 440)) - 140;
      w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      h = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
      b = int'($urandom_range(0, 4095));
      run_cmd(x, y, w, h, b, 1'($urandom_range(0, 1)), 1'b1, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
